// File: rtl/har_bnn1_pkg.sv
// Shared sizes, default binary weights and FSM state type for the HAR binary
// neural network classifier.
package har_bnn1_pkg;

  localparam int unsigned FEAT_CNT   = 12;
  localparam int unsigned FEAT_BITS  = 4;
  localparam int unsigned HIDDEN_CNT = 40;
  localparam int unsigned CLASS_CNT  = 6;
  localparam int unsigned SUM_BITS   = $clog2(HIDDEN_CNT + 1);
  localparam int unsigned STEP_BITS  = 6;

  // Bit [h*FEAT_CNT+f]: 1 = +1, 0 = -1. The 96-bit pattern repeats every 8 neurons.
  localparam logic [HIDDEN_CNT*FEAT_CNT-1:0] W1_DEFAULT =
    {5{96'h3A5_C96_E1B_74D_0F2_8B6_5D9_A23}};

  // Bit [c*HIDDEN_CNT+h]; the 48-bit period is not a multiple of 40, so the class rows differ.
  localparam logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_DEFAULT =
    {5{48'hB7E_153_A9C_4D2}};

  typedef enum logic [1:0] {
    ST_HIDDEN,
    ST_CLASS,
    ST_DONE
  } bnn_state_e;

endpackage

// File: rtl/har_bnn1_bnnroclk0_xnor_popcount.sv
// Binary-neuron agreement count: popcount of XNOR between activations and a weight row.
module bnn_xnor_popcount
  import har_bnn1_pkg::*;
#(
  parameter int unsigned WIDTH    = har_bnn1_pkg::HIDDEN_CNT,
  parameter int unsigned CNT_BITS = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [CNT_BITS-1:0] count
);

  logic [WIDTH-1:0] match;

  always_comb begin
    match = ~(a ^ b);
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + CNT_BITS'(match[i]);
    end
  end

endmodule

// File: rtl/har_bnn1_bnnroclk0.sv
// Sequential BNN classifier: one hidden neuron per clock, then one class score
// per clock with a running argmax; the registered prediction updates once at completion.
module har_bnn1_bnnroclk0
  import har_bnn1_pkg::*;
#(
  parameter int unsigned FEAT_CNT   = har_bnn1_pkg::FEAT_CNT,
  parameter int unsigned FEAT_BITS  = har_bnn1_pkg::FEAT_BITS,
  parameter int unsigned HIDDEN_CNT = har_bnn1_pkg::HIDDEN_CNT,
  parameter int unsigned CLASS_CNT  = har_bnn1_pkg::CLASS_CNT,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = W1_DEFAULT,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = W2_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]  features,
  output logic [$clog2(CLASS_CNT)-1:0]   prediction
);

  localparam int unsigned IDX_BITS   = $clog2(CLASS_CNT);
  localparam int unsigned SCORE_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int unsigned ACC_BITS   = $clog2(FEAT_CNT * ((1 << FEAT_BITS) - 1) + 1) + 1;
  localparam int unsigned LAST_STEP  = HIDDEN_CNT + CLASS_CNT - 1;

  bnn_state_e                    state_q, state_d;
  logic [STEP_BITS-1:0]          step_q, step_d;
  logic [HIDDEN_CNT-1:0]         hidden_q, hidden_d;
  logic [SCORE_BITS-1:0]         best_score_q;
  logic [IDX_BITS-1:0]           best_idx_q;
  logic [FEAT_CNT-1:0]           w1_row;
  logic [HIDDEN_CNT-1:0]         w2_row;
  logic signed [ACC_BITS-1:0]    acc;
  logic [SCORE_BITS-1:0]         score;
  logic [IDX_BITS-1:0]           class_idx;
  logic [IDX_BITS-1:0]           win_idx;
  logic                          take;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      ST_HIDDEN: begin
        step_d = step_q + 1'b1;
        if (step_q == STEP_BITS'(HIDDEN_CNT - 1)) state_d = ST_CLASS;
      end
      ST_CLASS: begin
        step_d = step_q + 1'b1;
        if (step_q == STEP_BITS'(LAST_STEP)) state_d = ST_DONE;
      end
      default: begin
        state_d = ST_DONE;
      end
    endcase
  end

  // Constant-index row muxes keep every weight select in range for all step values.
  always_comb begin
    w1_row = '0;
    for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
      if (step_q == STEP_BITS'(h)) w1_row = W1[h*FEAT_CNT +: FEAT_CNT];
    end
  end

  always_comb begin
    acc = '0;
    for (int unsigned f = 0; f < FEAT_CNT; f++) begin
      if (w1_row[f]) acc = acc + ACC_BITS'(features[f*FEAT_BITS +: FEAT_BITS]);
      else           acc = acc - ACC_BITS'(features[f*FEAT_BITS +: FEAT_BITS]);
    end
  end

  always_comb begin
    hidden_d = hidden_q;
    if (state_q == ST_HIDDEN) begin
      for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
        if (step_q == STEP_BITS'(h)) hidden_d[h] = ~acc[ACC_BITS-1];
      end
    end
  end

  always_comb begin
    class_idx = '0;
    w2_row    = '0;
    for (int unsigned c = 0; c < CLASS_CNT; c++) begin
      if (step_q == STEP_BITS'(HIDDEN_CNT + c)) begin
        class_idx = IDX_BITS'(c);
        w2_row    = W2[c*HIDDEN_CNT +: HIDDEN_CNT];
      end
    end
  end

  bnn_xnor_popcount #(
    .WIDTH    (HIDDEN_CNT),
    .CNT_BITS (SCORE_BITS)
  ) u_xnor_popcount (
    .a     (hidden_q),
    .b     (w2_row),
    .count (score)
  );

  // Strict '>' keeps the lowest index on ties; class 0 always seeds the search.
  always_comb begin
    take    = (class_idx == '0) || (score > best_score_q);
    win_idx = take ? class_idx : best_idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HIDDEN;
      step_q       <= '0;
      hidden_q     <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      prediction   <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      hidden_q <= hidden_d;
      if (state_q == ST_CLASS) begin
        if (take) begin
          best_score_q <= score;
          best_idx_q   <= class_idx;
        end
        if (step_q == STEP_BITS'(LAST_STEP)) prediction <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_har_bnn1_bnnroclk0.sv
// Directed and random checks of the BNN classifier across four weight configurations.
module tb_har_bnn1_bnnroclk0;
  import har_bnn1_pkg::*;

  localparam int unsigned FW = FEAT_CNT * FEAT_BITS;
  localparam logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1_ONES  = '1;
  localparam logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1_ZEROS = '0;
  localparam logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_ROW3  = {80'b0, {40{1'b1}}, 120'b0};
  localparam logic [CLASS_CNT*HIDDEN_CNT-1:0] W2_SAME  = {6{40'hC35A960FE1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [FW-1:0] features = '0;
  logic [2:0]    pred_a, pred_b, pred_c, pred_d;
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  har_bnn1_bnnroclk0 #(.W1(W1_ONES), .W2(W2_ROW3)) u_a (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_a));
  har_bnn1_bnnroclk0 #(.W1(W1_ZEROS), .W2(W2_ROW3)) u_b (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_b));
  har_bnn1_bnnroclk0 #(.W2(W2_SAME)) u_c (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_c));
  har_bnn1_bnnroclk0 u_d (
    .clk(clk), .rst(rst), .features(features), .prediction(pred_d));

  typedef struct {
    logic [FW-1:0] feat;
    logic [2:0]    exp_a;
    logic [2:0]    exp_b;
    logic [2:0]    exp_c;
  } vec_t;

  vec_t tbl[6];

  function automatic logic [2:0] model_pred(input logic [FW-1:0] feat);
    logic [HIDDEN_CNT-1:0] hid;
    int s;
    int score;
    int best;
    logic [2:0] bi;
    hid  = '0;
    best = 0;
    bi   = '0;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      s = 0;
      for (int f = 0; f < FEAT_CNT; f++) begin
        if (W1_DEFAULT[h*FEAT_CNT + f]) s = s + int'(feat[f*FEAT_BITS +: FEAT_BITS]);
        else                            s = s - int'(feat[f*FEAT_BITS +: FEAT_BITS]);
      end
      hid[h] = (s >= 0);
    end
    for (int c = 0; c < CLASS_CNT; c++) begin
      score = 0;
      for (int h = 0; h < HIDDEN_CNT; h++) begin
        if (hid[h] == W2_DEFAULT[c*HIDDEN_CNT + h]) score++;
      end
      if (c == 0 || score > best) begin
        best = score;
        bi   = 3'(c);
      end
    end
    return bi;
  endfunction

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reset released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] r;

    tbl[0] = '{48'h000000000000, 3'd3, 3'd3, 3'd0};
    tbl[1] = '{48'hFFFFFFFFFFFF, 3'd3, 3'd0, 3'd0};
    tbl[2] = '{48'h000000000001, 3'd3, 3'd0, 3'd0};
    tbl[3] = '{48'h0F0F0F0F0F0F, 3'd3, 3'd0, 3'd0};
    tbl[4] = '{48'h123456789ABC, 3'd3, 3'd0, 3'd0};
    tbl[5] = '{48'h800000000000, 3'd3, 3'd0, 3'd0};

    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_a", pred_a, 3'd0);
    check("reset_b", pred_b, 3'd0);
    check("reset_c", pred_c, 3'd0);
    check("reset_d", pred_d, 3'd0);

    for (int i = 0; i < 6; i++) begin
      features = tbl[i].feat;
      do_reset();
      run_edges(46);
      check($sformatf("tbl%0d_a", i), pred_a, tbl[i].exp_a);
      check($sformatf("tbl%0d_b", i), pred_b, tbl[i].exp_b);
      check($sformatf("tbl%0d_c", i), pred_c, tbl[i].exp_c);
      check($sformatf("tbl%0d_d", i), pred_d, model_pred(tbl[i].feat));
    end

    features = 48'hA5A5_3C3C_9696;
    do_reset();
    check("lat_release", pred_a, 3'd0);
    for (int k = 1; k <= 45; k++) begin
      run_edges(1);
      check($sformatf("lat_edge%0d", k), pred_a, 3'd0);
    end
    run_edges(1);
    check("lat_edge46", pred_a, 3'd3);
    run_edges(100);
    check("lat_hold", pred_a, 3'd3);

    // Asynchronous clear from DONE, between clock edges.
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_clr", pred_a, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    run_edges(20);
    check("abort_pre", pred_a, 3'd0);
    rst = 1'b0;
    #1 check("abort_clr", pred_a, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    run_edges(45);
    check("abort_edge45", pred_a, 3'd0);
    run_edges(1);
    check("abort_edge46", pred_a, 3'd3);

    for (int i = 0; i < 1000; i++) begin
      r = {$urandom(), $urandom()};
      features = r[FW-1:0];
      do_reset();
      run_edges(47);
      check($sformatf("rand%0d_d", i), pred_d, model_pred(features));
      check($sformatf("rand%0d_c", i), pred_c, 3'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/har_bnn1_bnnroclk0.md
HAR_BNN1_BNNROCLK0 -- requirements
Module: har_bnn1_bnnroclk0

Interface
REQ-001 Parameter FEAT_CNT, default 12: number of input features.
REQ-002 Parameter FEAT_BITS, default 4: unsigned width of each feature.
REQ-003 Parameter HIDDEN_CNT, default 40: number of hidden binary neurons.
REQ-004 Parameter CLASS_CNT, default 6: number of output classes.
REQ-005 Parameter W1 and its default:
- Width HIDDEN_CNT*FEAT_CNT bits; default from the package.
- Bit [h*FEAT_CNT+f] = 1 means weight +1 for hidden neuron h, feature f; 0 means -1.
REQ-006 Parameter W2 and its default:
- Width CLASS_CNT*HIDDEN_CNT bits; default from the package.
- Bit [c*HIDDEN_CNT+h] is the binary weight of hidden h to class c.
REQ-007 clk  input  1: single clock; all state updates on the rising edge.
REQ-008 rst  input  1: reset, asynchronous, active-low.
REQ-009 features  input  FEAT_BITS*FEAT_CNT: feature f occupies bits [f*FEAT_BITS +: FEAT_BITS].
REQ-010 prediction  output  $clog2(CLASS_CNT) (3): index of the winning class, registered.

Function
REQ-011 Sequencing:
- One 6-bit step counter drives three states: HIDDEN (steps 0..HIDDEN_CNT-1), CLASS (next CLASS_CNT steps), DONE.
- The block enters HIDDEN at the first rising edge after rst deasserts.
REQ-012 HIDDEN step h computes one neuron per clock, all features in parallel:
- s = sum over f of (W1 bit ? +x_f : -x_f), 9-bit signed, range -180..+180.
- hidden[h] <= (s >= 0); zero counts as 1.
REQ-013 CLASS step c:
- score = popcount(XNOR(hidden, W2 row c)), 6-bit unsigned, range 0..40.
- Update best_score/best_idx only if score > best_score; ties keep the lower index.
- Class 0 always loads.
REQ-014 At the edge that evaluates the last class:
- prediction <= the final argmax; the state becomes DONE.
- Latency is exactly HIDDEN_CNT+CLASS_CNT = 46 rising edges after reset release.
REQ-015 In DONE the counter stops and prediction holds until the next reset.
REQ-016 features are used directly and are not captured; they must stay stable from reset release until DONE.
REQ-017 prediction changes only at completion; intermediate best values are never visible at the output.

Reset
REQ-018 rst low asynchronously clears the counter, the hidden register, best_score, best_idx and prediction to 0, and holds state at HIDDEN step 0.
REQ-019 Reset asserted mid-computation aborts the computation; after release a full 46-cycle computation restarts.

Structure
REQ-020 Package har_bnn1_pkg holds:
- the size constants;
- SUM_BITS = $clog2(HIDDEN_CNT+1);
- the default W1/W2 weight vectors.
REQ-021 One sub-module, bnn_xnor_popcount (HIDDEN_CNT-bit XNOR plus popcount).
REQ-022 The top holds the counter/FSM, the signed feature accumulator and the argmax.
REQ-023 No memories; weights are constants; implementation is 120-400 lines of RTL.

Verification
REQ-024 Set W1 all 1, W2 row 3 all 1 and other rows all 0, features arbitrary -> hidden all 1, prediction 3 after 46 cycles.
REQ-025 Set W1 all 0, W2 row 3 all 1 and other rows all 0:
- features all 0 -> s=0 -> prediction 3;
- features all 0xF -> hidden all 0, classes 0,1,2,4,5 tie at 40 -> prediction 0.
REQ-026 Set all W2 rows identical -> prediction 0 (tie rule) for any features.
REQ-027 Check latency using the REQ-024 setup:
- prediction = 0 after rising edges 1..45 post-release;
- prediction = 3 after edge 46;
- prediction still 3 after 100 further edges.
REQ-028 Using the REQ-024 setup, assert rst low at step 20 -> prediction 0 immediately; after release, prediction 3 only after another 46 edges.
REQ-029 With the default weights, apply 1000 random feature vectors, each with reset then 47 cycles -> prediction matches a bit-exact golden model of REQ-012/REQ-013.
